// File: rtl/bp_update_queue_if.sv
// Handshake bundle between fetch/resolve logic and the branch-predictor update queue.
// The queue sits on the slave side; fetch, execute and the predictor sit on the master side.
interface bp_update_queue_if #(
  parameter int PC_BITS = 32,
  parameter int DEPTH   = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               push_valid;
  logic               push_ready;
  logic [PC_BITS-1:0] push_pc;
  logic               push_pred_taken;
  logic               res_valid;
  logic               res_taken;
  logic [PC_BITS-1:0] res_target;
  logic               flush;
  logic               upd_wr_en;
  logic [PC_BITS-1:0] upd_orig_pc;
  logic               upd_is_taken;
  logic               mispredict;
  logic [PC_BITS-1:0] redirect_pc;
  logic [CNT_W-1:0]   count;

  modport master (
    output push_valid, push_pc, push_pred_taken,
    output res_valid, res_taken, res_target, flush,
    input  push_ready, upd_wr_en, upd_orig_pc, upd_is_taken,
    input  mispredict, redirect_pc, count
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken,
    input  res_valid, res_taken, res_target, flush,
    output push_ready, upd_wr_en, upd_orig_pc, upd_is_taken,
    output mispredict, redirect_pc, count
  );
endinterface

// File: rtl/bp_update_queue.sv
// In-order queue of predicted branches; pairs each in-order resolution with the head entry,
// emits a registered gshare update, and squashes younger entries on a direction mismatch.
module bp_update_queue #(
  parameter int PC_BITS = 32,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bp_update_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_BITS-1:0] pc_mem   [DEPTH];
  logic               pred_mem [DEPTH];

  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   cnt;

  logic               full, res_eff, mis_p0, push_eff;
  logic [PC_BITS-1:0] head_pc;
  logic               head_pred;

  logic               upd_wr_en_p1, upd_is_taken_p1, mispredict_p1;
  logic [PC_BITS-1:0] upd_orig_pc_p1, redirect_pc_p1;

  function automatic logic [PC_BITS-1:0] redirect_target(
    input logic               taken,
    input logic [PC_BITS-1:0] target,
    input logic [PC_BITS-1:0] pc
  );
    return taken ? target : pc + PC_BITS'(4);
  endfunction

  // Stage p0: head lookup and resolve/push qualification
  assign full      = (cnt == CNT_W'(DEPTH));
  assign head_pc   = pc_mem[head];
  assign head_pred = pred_mem[head];
  assign res_eff   = q.res_valid && (cnt != '0) && !q.flush;
  assign mis_p0    = res_eff && (q.res_taken != head_pred);
  assign push_eff  = q.push_valid && !full && !q.flush && !mis_p0;

  always_ff @(posedge clk) begin
    if (push_eff) begin
      pc_mem[tail]   <= q.push_pc;
      pred_mem[tail] <= q.push_pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (q.flush || mis_p0) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (res_eff)  head <= head + PTR_W'(1);
      if (push_eff) tail <= tail + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_eff) - CNT_W'(res_eff);
    end
  end

  // Stage p1: registered predictor update and redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_wr_en_p1    <= 1'b0;
      upd_orig_pc_p1  <= '0;
      upd_is_taken_p1 <= 1'b0;
      mispredict_p1   <= 1'b0;
      redirect_pc_p1  <= '0;
    end else begin
      upd_wr_en_p1  <= res_eff;
      mispredict_p1 <= mis_p0;
      if (res_eff) begin
        upd_orig_pc_p1  <= head_pc;
        upd_is_taken_p1 <= q.res_taken;
      end
      if (mis_p0) redirect_pc_p1 <= redirect_target(q.res_taken, q.res_target, head_pc);
    end
  end

  assign q.push_ready   = !full;
  assign q.count        = cnt;
  assign q.upd_wr_en    = upd_wr_en_p1;
  assign q.upd_orig_pc  = upd_orig_pc_p1;
  assign q.upd_is_taken = upd_is_taken_p1;
  assign q.mispredict   = mispredict_p1;
  assign q.redirect_pc  = redirect_pc_p1;
endmodule

// File: doc/bp_update_queue.md
Name: bp_update_queue

Overview:
- In-order queue of predicted conditional branches, sitting between fetch and the gshare direction predictor's update interface.
- Fetch pushes each predicted branch. Resolution from execute/commit arrives strictly in program order and pairs with the head entry.
- On each resolution the block drives one registered predictor update (wr_en/orig_pc/is_taken). On a direction mismatch it raises a mispredict redirect and squashes all younger entries.

Parameters:
- PC_BITS, 32: PC address width.
- DEPTH, 8: number of queue entries; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  1  fetch presents a predicted branch.
- push_ready  out  1  queue can accept; equals !full.
- push_pc  in  PC_BITS  branch PC.
- push_pred_taken  in  1  predicted direction.
- res_valid  in  1  head branch resolved this cycle.
- res_taken  in  1  actual direction.
- res_target  in  PC_BITS  actual taken target.
- flush  in  1  external squash (exception/commit flush).
- upd_wr_en  out  1  predictor update strobe.
- upd_orig_pc  out  PC_BITS  PC being updated.
- upd_is_taken  out  1  actual direction for update.
- mispredict  out  1  one-cycle redirect pulse.
- redirect_pc  out  PC_BITS  correct next fetch PC.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, rst_n low):
  - head, tail, count = 0.
  - upd_wr_en = 0, upd_orig_pc = 0, upd_is_taken = 0.
  - mispredict = 0, redirect_pc = 0.
  - push_ready = 1.
  - Entry storage need not be reset.
- Reset asserted mid-operation discards all entries immediately; no update is emitted.
- Push:
  - Accepted on a clk edge when push_valid & push_ready & !flush & !squash.
  - Stores {push_pc, push_pred_taken} at tail; tail advances modulo DEPTH.
- Full:
  - push_ready = 0 when count == DEPTH, even if a resolution pops in the same cycle.
  - push_ready is combinational from count only.
- Resolve:
  - Effective when res_valid & (count != 0) & !flush.
  - Head entry is read combinationally; head advances.
  - At the next edge (latency 1), registered for exactly one cycle: upd_wr_en = 1, upd_orig_pc = head pc, upd_is_taken = res_taken.
- Resolve on empty queue: ignored; no update, no pointer change.
- Mispredict:
  - Condition: effective resolve with res_taken != head pred_taken.
  - Next cycle: mispredict = 1.
  - redirect_pc = res_target if res_taken, else head pc + 4 (PC_BITS wrap-around arithmetic).
  - Same edge (squash): head = tail = count = 0, discarding all younger entries.
  - Any push offered in the resolving cycle is dropped.
  - The update for the mispredicted branch itself is still emitted.
- Correct prediction: mispredict stays 0; redirect_pc holds its previous value.
- Simultaneous push + resolve (correct prediction, not full): both take effect; count unchanged.
- flush:
  - Highest priority among push/resolve: pointers and count cleared next edge.
  - A same-cycle resolve is dropped: no update, no mispredict.
  - Pending registered outputs from the previous cycle still complete their single-cycle pulse.
- Wrap-around: pointers use $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Outputs hold between strobes except upd_wr_en and mispredict, which return to 0.

Test Plan:
- Reset, then push PCs 0x100/T, 0x200/N, 0x300/T; resolve T, N, T on consecutive cycles → three upd_wr_en pulses, each one cycle after its resolve, with orig_pc 0x100/0x200/0x300 and is_taken 1/0/1; mispredict never asserted; count 3→0.
- Push 8 entries → push_ready = 0 and count = 8. Push+resolve in the same cycle → push rejected, count = 7. Push 4 more across pointer wrap → FIFO order preserved on resolve.
- Push 0x400/T and 0x500/N; resolve not-taken → next cycle upd_wr_en = 1, orig_pc = 0x400, is_taken = 0, mispredict = 1, redirect_pc = 0x404, count = 0; 0x500 never updated.
- Push 0x600/N; resolve taken with res_target 0x1000 → mispredict = 1, redirect_pc = 0x1000. Push 0xFFFFFFFC/T and resolve N → redirect_pc = 0x00000000.
- With 3 entries, assert flush together with res_valid → no upd_wr_en, no mispredict, count = 0. res_valid on the empty queue → no response.
- Assert rst_n low while upd_wr_en is high and 5 entries are held → all outputs 0 immediately, count = 0, push_ready = 1.
